// File: rtl/segment_capture.sv
// Reads a multiplexed 4-digit 7-segment bus. It debounces each digit strobe, decodes the glyphs
// to BCD, and rebuilds the {hours,minutes} time word. It flags bad glyphs, out-of-range times and stalled scans.
module segment_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  digit_sel,
   input  logic [6:0]  segment,
   output logic [11:0] data_out,
   output logic        data_valid,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] STAB_ARM = SW'(STABLE_CYCLES - 2);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      ASSEMBLE = 2'd2
   } state_t;

   state_t          state;
   logic [10:0]     sample;
   logic [10:0]     prev_sample;
   logic [SW-1:0]   stab_cnt;
   logic [TW-1:0]   to_cnt;
   logic [3:0]      mask;
   logic [3:0][3:0] digits;   // [0] min ones, [1] min tens, [2] hr ones, [3] hr tens

   logic [3:0] sel_s;
   logic [6:0] seg_s;
   logic       same;
   logic       accept;
   logic       sel_onehot;
   logic [4:0] dec;
   logic       glyph_ok;
   logic       glyph_bad;
   logic [3:0] mask_next;
   logic [6:0] min_val;
   logic [6:0] hr_val;
   logic       range_bad;

   // Returns {known, bcd}; anything outside the ten digit shapes is unknown.
   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h3F:   r = {1'b1, 4'd0};
         7'h06:   r = {1'b1, 4'd1};
         7'h5B:   r = {1'b1, 4'd2};
         7'h4F:   r = {1'b1, 4'd3};
         7'h66:   r = {1'b1, 4'd4};
         7'h6D:   r = {1'b1, 4'd5};
         7'h7D:   r = {1'b1, 4'd6};
         7'h07:   r = {1'b1, 4'd7};
         7'h7F:   r = {1'b1, 4'd8};
         7'h6F:   r = {1'b1, 4'd9};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   assign sel_s      = sample[10:7];
   assign seg_s      = sample[6:0];
   assign same       = (sample == prev_sample);
   // Fires on the single cycle the counter steps onto its saturation value.
   assign accept     = same && (stab_cnt == STAB_ARM);
   assign sel_onehot = (sel_s != 4'd0) && ((sel_s & (sel_s - 4'd1)) == 4'd0);
   assign dec        = decode(seg_s);
   assign glyph_ok   = accept && sel_onehot && dec[4];
   assign glyph_bad  = accept && (sel_s != 4'd0) && !(sel_onehot && dec[4]);
   assign mask_next  = mask | (glyph_ok ? sel_s : 4'd0);

   assign min_val    = {3'b000, digits[1]} * 7'd10 + {3'b000, digits[0]};
   assign hr_val     = {3'b000, digits[3]} * 7'd10 + {3'b000, digits[2]};
   assign range_bad  = (min_val > 7'd59) || (hr_val > 7'd23);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         sample      <= '0;
         prev_sample <= '0;
         stab_cnt    <= '0;
         to_cnt      <= '0;
         mask        <= '0;
         digits      <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'b00;
      end else begin
         prev_sample <= sample;
         sample      <= {digit_sel, segment};
         data_valid  <= 1'b0;
         err         <= 1'b0;

         if (!same)
            stab_cnt <= '0;
         else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + 1'b1;

         for (int i = 0; i < 4; i++) begin
            if (glyph_ok && sel_s[i])
               digits[i] <= dec[3:0];
         end

         // While a frame is being assembled its outcome owns the err/data_valid pulse.
         if (glyph_bad && (state != ASSEMBLE)) begin
            err      <= 1'b1;
            err_code <= 2'b01;
         end

         case (state)
            IDLE: begin
               mask <= mask_next;
               if (glyph_ok) begin
                  to_cnt <= '0;
                  state  <= COLLECT;
               end
            end
            COLLECT: begin
               if (mask == 4'b1111) begin
                  state <= ASSEMBLE;
               end else if ((to_cnt == TO_LAST) && (mask_next != 4'b1111)) begin
                  err      <= 1'b1;
                  err_code <= 2'b11;
                  mask     <= '0;
                  state    <= IDLE;
               end else begin
                  // A last digit landing on the timeout edge completes the frame instead.
                  mask <= mask_next;
                  if (to_cnt != TO_LAST)
                     to_cnt <= to_cnt + 1'b1;
               end
            end
            ASSEMBLE: begin
               if (range_bad) begin
                  err      <= 1'b1;
                  err_code <= 2'b10;
               end else begin
                  data_out   <= {hr_val[5:0], min_val[5:0]};
                  data_valid <= 1'b1;
               end
               mask  <= glyph_ok ? sel_s : 4'd0;
               state <= IDLE;
            end
            default: begin
               mask  <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
